// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD up/down counter wrapping at a programmable terminal value,
// with prescaler, load, terminal flag and seven-segment decode. BCD_BLANK_EN blanks leading zeros.
module bcd_mod_counter #(
  parameter int DIGITS = 3,
  parameter int DIV    = 25000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [4*DIGITS-1:0]   mod_val,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic [7*DIGITS-1:0]   seg
);
  localparam int W  = 4 * DIGITS;
  localparam int SW = 7 * DIGITS;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

  logic [PW-1:0] ps_q, ps_d;
  logic          tick;
  logic [W-1:0]  q_q, q_d;
  logic          tc_q, tc_d;
  logic [SW-1:0] seg_q, seg_d, seg_rst;

  // Digits above 9 are handled as 9 only when the carry reaches them.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    logic [3:0]   d;
    r = v;
    c = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      d = v[4*k +: 4];
      if (c) begin
        if (d >= 4'd9) begin
          d = 4'd0;
        end else begin
          d = d + 4'd1;
          c = 1'b0;
        end
        r[4*k +: 4] = d;
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    logic [3:0]   d;
    r = v;
    b = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      d = v[4*k +: 4];
      if (b) begin
        if (d == 4'd0) begin
          d = 4'd9;
        end else if (d > 4'd9) begin
          d = 4'd8;
          b = 1'b0;
        end else begin
          d = d - 4'd1;
          b = 1'b0;
        end
        r[4*k +: 4] = d;
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  function automatic logic [SW-1:0] seg_encode(input logic [W-1:0] v);
    logic [SW-1:0] r;
`ifdef BCD_BLANK_EN
    logic lead;
    lead = 1'b1;
    r    = '1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (k > 0 && lead && v[4*k +: 4] == 4'd0) begin
        r[7*k +: 7] = 7'b1111111;
      end else begin
        lead        = 1'b0;
        r[7*k +: 7] = seg7(v[4*k +: 4]);
      end
    end
`else
    r = '1;
    for (int k = 0; k < DIGITS; k++) begin
      r[7*k +: 7] = seg7(v[4*k +: 4]);
    end
`endif
    return r;
  endfunction

  always_comb begin
    tick = (ps_q == PS_LAST);
    ps_d = tick ? '0 : ps_q + PW'(1);

    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (tick && en) begin
      if (up) begin
        q_d = (q_q < mod_val) ? bcd_inc(q_q) : '0;
      end else begin
        q_d = (q_q == '0 || q_q > mod_val) ? mod_val : bcd_dec(q_q);
      end
    end

    tc_d    = up ? (q_q == mod_val) : (q_q == '0);
    seg_d   = seg_encode(q_q);
    seg_rst = seg_encode('0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q  <= '0;
      q_q   <= '0;
      tc_q  <= 1'b0;
      seg_q <= seg_rst;
    end else begin
      ps_q  <= ps_d;
      q_q   <= q_d;
      tc_q  <= tc_d;
      seg_q <= seg_d;
    end
  end

  assign q   = q_q;
  assign tc  = tc_q;
  assign seg = seg_q;
endmodule

// File: tb/tb_bcd_mod_counter.sv
// Scoreboard bench for bcd_mod_counter (DIGITS=3, DIV=2); honours BCD_BLANK_EN for seg expectations.
module tb_bcd_mod_counter;
  logic        clk = 1'b0;
  logic        rst, en, up, load;
  logic [11:0] load_val, mod_val;
  logic [11:0] q;
  logic        tc;
  logic [20:0] seg;

  typedef struct {
    logic [11:0] q;
    logic        tc;
    logic [20:0] seg;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [11:0] prev_q = 12'h000;
  int          ph = 0;

  bcd_mod_counter #(.DIGITS(3), .DIV(2)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .mod_val(mod_val), .q(q), .tc(tc), .seg(seg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
          7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111,
          7'b1111111};
    return t[d];
  endfunction

  function automatic logic [20:0] seg_model(input logic [11:0] v);
    logic [20:0] r;
    r = {seg_digit(v[11:8]), seg_digit(v[7:4]), seg_digit(v[3:0])};
`ifdef BCD_BLANK_EN
    if (v[11:8] == 4'd0) begin
      r[20:14] = 7'b1111111;
      if (v[7:4] == 4'd0) r[13:7] = 7'b1111111;
    end
`endif
    return r;
  endfunction

  function automatic int bcd2int(input logic [11:0] v);
    return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [11:0] int2bcd(input int n);
    logic [11:0] r;
    r[11:8] = 4'((n / 100) % 10);
    r[7:4]  = 4'((n / 10) % 10);
    r[3:0]  = 4'(n % 10);
    return r;
  endfunction

  // Decimal reference step; valid only for legal BCD operands.
  function automatic logic [11:0] step_model(input logic [11:0] v, input logic [11:0] m, input logic u);
    int qi, mi;
    qi = bcd2int(v);
    mi = bcd2int(m);
    if (u) return (qi < mi) ? int2bcd(qi + 1) : 12'h000;
    else   return (qi == 0 || qi > mi) ? m : int2bcd(qi - 1);
  endfunction

  // One clock: predict this edge's outputs, wait for the edge, hand the expectation to the monitor.
  task automatic cyc(input bit use_model, input logic [11:0] eq_in);
    exp_t        e;
    logic [11:0] eq;
    bit          tk;
    tk = (ph == 1);
    if (rst)            eq = 12'h000;
    else if (!use_model) eq = eq_in;
    else if (load)      eq = load_val;
    else if (tk && en)  eq = step_model(prev_q, mod_val, up);
    else                eq = prev_q;
    e.q   = eq;
    e.tc  = rst ? 1'b0 : (up ? (prev_q == mod_val) : (prev_q == 12'h000));
    e.seg = rst ? seg_model(12'h000) : seg_model(prev_q);
    @(posedge clk);
    sb.push_back(e);
    prev_q = eq;
    ph = rst ? 0 : (ph ^ 1);
    #1;
  endtask

  task automatic cm(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 12'h000);
  endtask

  task automatic ce(input logic [11:0] eq);
    cyc(1'b0, eq);
  endtask

  task automatic tick_to(input logic [11:0] hold_v, input logic [11:0] next_v);
    while (ph != 1) ce(hold_v);
    ce(next_v);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (q !== e.q) begin
        failures++;
        $display("FAIL q at %0t: got %h expected %h", $time, q, e.q);
      end
      checks++;
      if (tc !== e.tc) begin
        failures++;
        $display("FAIL tc at %0t: got %b expected %b (q=%h)", $time, tc, e.tc, q);
      end
      checks++;
      if (seg !== e.seg) begin
        failures++;
        $display("FAIL seg at %0t: got %b expected %b (q=%h)", $time, seg, e.seg, q);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0;
    load_val = 12'h000; mod_val = 12'h115;
    cyc(1'b1, 12'h000);
    cyc(1'b1, 12'h000);
    rst = 1'b0;

    // Full up-count 000..115 and wrap to 000.
    cm(2 * 117 + 4);

    // Double carry up, double borrow down.
    load = 1'b1; load_val = 12'h099; ce(12'h099); load = 1'b0;
    tick_to(12'h099, 12'h100);
    up = 1'b0;
    tick_to(12'h100, 12'h099);

    // Down count with mod 015 from 000.
    mod_val = 12'h015; load = 1'b1; load_val = 12'h000; ce(12'h000); load = 1'b0;
    tick_to(12'h000, 12'h015);
    tick_to(12'h015, 12'h014);
    cm(2 * 16 + 2);

    // Load beats a coincident tick; then enable low freezes q.
    mod_val = 12'h115; up = 1'b1;
    while (ph != 1) cm(1);
    load = 1'b1; load_val = 12'h042; ce(12'h042); load = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 20; i++) ce(12'h042);
    en = 1'b1;
    tick_to(12'h042, 12'h043);

    // Terminal value lowered below current q.
    load = 1'b1; load_val = 12'h100; ce(12'h100); load = 1'b0;
    mod_val = 12'h015;
    tick_to(12'h100, 12'h000);
    load = 1'b1; load_val = 12'h100; ce(12'h100); load = 1'b0;
    up = 1'b0;
    tick_to(12'h100, 12'h015);

    // Non-BCD digit handling.
    mod_val = 12'h115; up = 1'b1;
    load = 1'b1; load_val = 12'h00A; ce(12'h00A); load = 1'b0;
    tick_to(12'h00A, 12'h010);
    load = 1'b1; load_val = 12'h00A; ce(12'h00A); load = 1'b0;
    up = 1'b0;
    tick_to(12'h00A, 12'h008);

    // Reset mid-count overrides a pending load, then prescaler restarts.
    up = 1'b1;
    load = 1'b1; load_val = 12'h007; ce(12'h007); load = 1'b0;
    cm(1);
    rst = 1'b1; load = 1'b1; load_val = 12'h055;
    cm(1);
    rst = 1'b0; load = 1'b0;
    ce(12'h000);
    ce(12'h001);
    cm(6);

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
